uart_rx_feed: RTL and testbench
===============================

UART_RX_FEED -- requirements
Module: uart_rx_feed

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per character.
REQ-002 SHALL have parameter CLKDIV, default 16, wclk cycles per bit; legal range 4..65535.
REQ-003 SHALL have port wclk  input  1  write-side clock; all logic on its rising edge.
REQ-004 SHALL have port wreset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rxd  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port wfull  input  1  downstream FIFO full flag, wclk domain.
REQ-007 SHALL have port wdata  output  WIDTH  received character; valid while wstore is high.
REQ-008 SHALL have port wstore  output  1  one-cycle push strobe to the FIFO.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit (or bad parity).
REQ-010 SHALL have port overrun  output  1  one-cycle pulse when a good character is dropped because wfull is high.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL pass rxd through a 2-flop synchronizer whose flops reset to 1; all decisions use the synchronized value.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-014 IDLE -> START when the synchronized rxd is 0; the bit counter loads CLKDIV/2 (integer division).
REQ-015 START: when the counter expires, sample rxd; 0 -> DATA with the counter reloaded to CLKDIV; 1 -> IDLE (false start), no output pulse.
REQ-016 DATA: sample once per CLKDIV cycles, LSB first, into a shift register; after WIDTH samples -> PARITY (macro defined) or STOP.
REQ-017 STOP: sample after CLKDIV cycles; 1 = good character, 0 = frame error.
REQ-018 Good character: in the following cycle wdata SHALL hold the character and either wstore=1 (wfull=0) or overrun=1 (wfull=1, character discarded, wstore stays 0); then -> IDLE.
REQ-019 wstore SHALL never assert while wfull is high, so a REPLACE-mode FIFO is never overwritten.
REQ-020 Frame error: frame_err=1 for one cycle, no store, -> BREAK.
REQ-021 BREAK: remain until synchronized rxd is 1, then -> IDLE; a held-low line yields exactly one frame_err.
REQ-022 wdata SHALL hold its last value between strobes.
REQ-023 At most one of wstore, overrun, frame_err SHALL be high in any cycle.
REQ-024 The bit counter SHALL be 16 bits wide; there is no wrap-around within a bit period.
REQ-025 Latency: falling edge of the start bit at the synchronizer input to wstore = 2 + CLKDIV/2 + (WIDTH+1)*CLKDIV + 1 cycles (plus CLKDIV with parity).

Reset
REQ-026 wreset high at a wclk edge SHALL force IDLE, synchronizer flops=1, counter=0, shift register=0, wdata=0, and wstore=frame_err=overrun=busy=0.
REQ-027 Reset mid-frame SHALL discard the partial character with no pulse; reception restarts at the next falling edge after release.

Configuration
REQ-028 Macro UART_RX_FEED_PARITY_EN defined: after DATA, the PARITY state samples one even-parity bit; a mismatch is treated as a frame error (REQ-020), including the move to BREAK.
REQ-029 Macro absent: the PARITY state and its logic are not compiled; DATA -> STOP directly.

Verification
REQ-030 CLKDIV=16, send 0xA5 with stop=1, wfull=0 -> a single wstore with wdata=0xA5 at the latency given in REQ-025.
REQ-031 Send 0x00, then 0xFF back-to-back (no idle gap) -> two wstores, wdata 0x00 then 0xFF, no error pulses.
REQ-032 Hold wfull=1, send 0x3C -> overrun pulses once, wstore stays 0.
REQ-033 Send 0x55 with stop=0, then hold rxd low for 40 bit times -> exactly one frame_err, no wstore; a following 0x12 is received correctly.
REQ-034 0-pulse on rxd of 5 wclk cycles -> START aborts to IDLE, no outputs; assert wreset in the middle of DATA -> no pulse, busy=0 the next cycle.
REQ-035 With UART_RX_FEED_PARITY_EN, send 0x07 with parity bit 1 (correct) -> wstore with wdata=0x07; parity bit 0 -> frame_err.

Source files
------------

// File: rtl/uart_rx_feed.sv
// UART receiver that pushes each good character into a wclk-domain FIFO, honouring its full flag.
// Optional even-parity bit after the data bits is enabled by defining UART_RX_FEED_PARITY_EN.
module uart_rx_feed #(
    parameter int WIDTH  = 8,
    parameter int CLKDIV = 16
) (
    input  logic             wclk,
    input  logic             wreset,
    input  logic             rxd,
    input  logic             wfull,
    output logic [WIDTH-1:0] wdata,
    output logic             wstore,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);
    localparam int              BCW      = $clog2(WIDTH + 1);
    localparam logic [15:0]     HALF_BIT = 16'(CLKDIV / 2);
    localparam logic [15:0]     FULL_BIT = 16'(CLKDIV);
    localparam logic [BCW-1:0]  LAST_BIT = BCW'(WIDTH - 1);

`ifdef UART_RX_FEED_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t           state_reg, state_next;
    logic [15:0]      cnt_reg, cnt_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [BCW-1:0]   bit_cnt_reg, bit_cnt_next;
    logic             sync1_reg, sync2_reg;
    logic             good_next, err_next;
    logic             good_d_reg, err_d_reg;
    logic             pulse_reg, frame_err_reg;
    logic [WIDTH-1:0] wdata_reg;
    logic             rx_s;
    logic             bit_due;

    assign rx_s    = sync2_reg;
    assign bit_due = (cnt_reg <= 16'd1);

    always_ff @(posedge wclk) begin
        if (wreset) begin
            sync1_reg     <= 1'b1;
            sync2_reg     <= 1'b1;
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            shift_reg     <= '0;
            bit_cnt_reg   <= '0;
            good_d_reg    <= 1'b0;
            err_d_reg     <= 1'b0;
            pulse_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            wdata_reg     <= '0;
        end else begin
            sync1_reg     <= rxd;
            sync2_reg     <= sync1_reg;
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            shift_reg     <= shift_next;
            bit_cnt_reg   <= bit_cnt_next;
            good_d_reg    <= good_next;
            err_d_reg     <= err_next;
            pulse_reg     <= good_d_reg;
            frame_err_reg <= err_d_reg;
            if (good_d_reg)
                wdata_reg <= shift_reg;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        good_next    = 1'b0;
        err_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    cnt_next   = HALF_BIT;
                end
            end
            START: begin
                if (bit_due) begin
                    if (!rx_s) begin
                        state_next   = DATA;
                        cnt_next     = FULL_BIT;
                        bit_cnt_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            DATA: begin
                if (bit_due) begin
                    shift_next = {rx_s, shift_reg[WIDTH-1:1]};
                    cnt_next   = FULL_BIT;
                    if (bit_cnt_reg == LAST_BIT) begin
`ifdef UART_RX_FEED_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
`ifdef UART_RX_FEED_PARITY_EN
            PARITY: begin
                if (bit_due) begin
                    cnt_next = FULL_BIT;
                    // Even parity: data ones plus the parity bit must total an even count
                    if ((^shift_reg) ^ rx_s) begin
                        err_next   = 1'b1;
                        state_next = BREAK;
                    end else begin
                        state_next = STOP;
                    end
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
`endif
            STOP: begin
                if (bit_due) begin
                    if (rx_s) begin
                        good_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = BREAK;
                    end
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            BREAK: begin
                if (rx_s)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Gate the push with the live full flag so a full FIFO is never written
    assign wstore    = pulse_reg & ~wfull;
    assign overrun   = pulse_reg & wfull;
    assign frame_err = frame_err_reg;
    assign wdata     = wdata_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_feed.sv
// Directed bench for uart_rx_feed: table of single frames plus hand-built multi-frame sequences.
module tb_uart_rx_feed;
    localparam int WIDTH  = 8;
    localparam int CLKDIV = 16;
`ifdef UART_RX_FEED_PARITY_EN
    localparam int PAR_CYC = CLKDIV;
`else
    localparam int PAR_CYC = 0;
`endif
    localparam int LATENCY = 2 + CLKDIV / 2 + (WIDTH + 1) * CLKDIV + 1 + PAR_CYC;

    logic             wclk = 1'b0;
    logic             wreset;
    logic             rxd;
    logic             wfull;
    logic [WIDTH-1:0] wdata;
    logic             wstore;
    logic             frame_err;
    logic             overrun;
    logic             busy;

    uart_rx_feed #(.WIDTH(WIDTH), .CLKDIV(CLKDIV)) dut (
        .wclk      (wclk),
        .wreset    (wreset),
        .rxd       (rxd),
        .wfull     (wfull),
        .wdata     (wdata),
        .wstore    (wstore),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 wclk = ~wclk;

    int cyc = 0;
    int n_store = 0, n_over = 0, n_ferr = 0;
    int excl_viol = 0, full_viol = 0;
    int store_cyc = 0, start_cyc = 0;
    logic [WIDTH-1:0] store_log[$];
    int n_checks = 0, n_pass = 0;

    always @(posedge wclk) cyc <= cyc + 1;

    always @(negedge wclk) begin
        if (wstore === 1'b1) begin
            n_store   <= n_store + 1;
            store_cyc <= cyc;
            store_log.push_back(wdata);
        end
        if (overrun === 1'b1)   n_over <= n_over + 1;
        if (frame_err === 1'b1) n_ferr <= n_ferr + 1;
        if ((32'(wstore === 1'b1) + 32'(overrun === 1'b1) + 32'(frame_err === 1'b1)) > 1)
            excl_viol <= excl_viol + 1;
        if (wstore === 1'b1 && wfull === 1'b1)
            full_viol <= full_viol + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge wclk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        tick(CLKDIV);
    endtask

    // Leaves rxd at the stop-bit level; caller decides what follows
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_bad);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_FEED_PARITY_EN
        drive_bit((^d) ^ par_bad);
`else
        if (par_bad) $display("note: parity vector sent without parity bit");
`endif
        drive_bit(stop);
    endtask

    typedef struct {
        string      name;
        logic [7:0] d;
        logic       stop;
        logic       par_bad;
        logic       full;
        int         e_store;
        int         e_over;
        int         e_ferr;
        logic [7:0] e_wdata;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int b_store, b_over, b_ferr, b_log;

        vecs.push_back('{"a5_good",   8'hA5, 1'b1, 1'b0, 1'b0, 1, 0, 0, 8'hA5});
        vecs.push_back('{"3c_full",   8'h3C, 1'b1, 1'b0, 1'b1, 0, 1, 0, 8'h3C});
        vecs.push_back('{"81_good",   8'h81, 1'b1, 1'b0, 1'b0, 1, 0, 0, 8'h81});
        vecs.push_back('{"55_badstp", 8'h55, 1'b0, 1'b0, 1'b0, 0, 0, 1, 8'h81});
        vecs.push_back('{"12_good",   8'h12, 1'b1, 1'b0, 1'b0, 1, 0, 0, 8'h12});
`ifdef UART_RX_FEED_PARITY_EN
        vecs.push_back('{"07_par_ok",  8'h07, 1'b1, 1'b0, 1'b0, 1, 0, 0, 8'h07});
        vecs.push_back('{"07_par_bad", 8'h07, 1'b1, 1'b1, 1'b0, 0, 0, 1, 8'h07});
`endif

        wreset = 1'b1;
        rxd    = 1'b1;
        wfull  = 1'b0;
        tick(3);
        check("rst_wdata",     32'(wdata),     32'h0);
        check("rst_wstore",    32'(wstore),    32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_overrun",   32'(overrun),   32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        wreset = 1'b0;
        tick(4);

        foreach (vecs[i]) begin
            b_store = n_store; b_over = n_over; b_ferr = n_ferr;
            wfull = vecs[i].full;
            send_frame(vecs[i].d, vecs[i].stop, vecs[i].par_bad);
            rxd = 1'b1;
            tick(3 * CLKDIV);
            wfull = 1'b0;
            check({vecs[i].name, "_store"}, 32'(n_store - b_store), 32'(vecs[i].e_store));
            check({vecs[i].name, "_over"},  32'(n_over - b_over),   32'(vecs[i].e_over));
            check({vecs[i].name, "_ferr"},  32'(n_ferr - b_ferr),   32'(vecs[i].e_ferr));
            check({vecs[i].name, "_wdata"}, 32'(wdata),             32'(vecs[i].e_wdata));
            if (vecs[i].e_store == 1)
                check({vecs[i].name, "_latency"}, 32'(store_cyc - start_cyc - 1), 32'(LATENCY));
            $display("vec %s data=%02h stop=%0b full=%0b -> stores=%0d overruns=%0d frame_errs=%0d wdata=%02h",
                     vecs[i].name, vecs[i].d, vecs[i].stop, vecs[i].full,
                     n_store - b_store, n_over - b_over, n_ferr - b_ferr, wdata);
        end

        // Back-to-back characters with no idle between stop and next start
        b_store = n_store; b_ferr = n_ferr; b_over = n_over; b_log = store_log.size();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        rxd = 1'b1;
        tick(3 * CLKDIV);
        check("b2b_store", 32'(n_store - b_store), 32'd2);
        check("b2b_first", 32'(store_log.size() > b_log ? store_log[b_log] : 8'hxx), 32'h00);
        check("b2b_second", 32'(store_log.size() > b_log + 1 ? store_log[b_log + 1] : 8'hxx), 32'hFF);
        check("b2b_errs", 32'((n_ferr - b_ferr) + (n_over - b_over)), 32'd0);
        $display("seq back_to_back -> stores=%0d", n_store - b_store);

        // Bad stop followed by a long break, then a normal character
        b_store = n_store; b_ferr = n_ferr;
        send_frame(8'h55, 1'b0, 1'b0);
        tick(40 * CLKDIV);
        check("brk_ferr_once", 32'(n_ferr - b_ferr), 32'd1);
        check("brk_no_store",  32'(n_store - b_store), 32'd0);
        check("brk_busy",      32'(busy), 32'd1);
        rxd = 1'b1;
        tick(2 * CLKDIV);
        send_frame(8'h12, 1'b1, 1'b0);
        rxd = 1'b1;
        tick(3 * CLKDIV);
        check("brk_then_store", 32'(n_store - b_store), 32'd1);
        check("brk_then_wdata", 32'(wdata), 32'h12);
        check("brk_ferr_total", 32'(n_ferr - b_ferr), 32'd1);
        $display("seq break -> frame_errs=%0d stores=%0d wdata=%02h", n_ferr - b_ferr, n_store - b_store, wdata);

        // Short glitch: false start aborts silently
        b_store = n_store; b_ferr = n_ferr; b_over = n_over;
        rxd = 1'b0;
        tick(3);
        check("glitch_busy_hi", 32'(busy), 32'd1);
        tick(2);
        rxd = 1'b1;
        tick(2 * CLKDIV);
        check("glitch_busy_lo", 32'(busy), 32'd0);
        check("glitch_no_out", 32'((n_store - b_store) + (n_ferr - b_ferr) + (n_over - b_over)), 32'd0);
        $display("seq glitch -> busy=%0b pulses=%0d", busy, (n_store - b_store) + (n_ferr - b_ferr) + (n_over - b_over));

        // Reset in the middle of the data bits
        b_store = n_store; b_ferr = n_ferr; b_over = n_over;
        start_cyc = cyc;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        check("mid_busy_before", 32'(busy), 32'd1);
        wreset = 1'b1;
        rxd    = 1'b1;
        tick(1);
        wreset = 1'b0;
        check("mid_busy_after", 32'(busy), 32'd0);
        tick(12 * CLKDIV);
        check("mid_no_out", 32'((n_store - b_store) + (n_ferr - b_ferr) + (n_over - b_over)), 32'd0);
        send_frame(8'h5A, 1'b1, 1'b0);
        rxd = 1'b1;
        tick(3 * CLKDIV);
        check("mid_restart_store", 32'(n_store - b_store), 32'd1);
        check("mid_restart_wdata", 32'(wdata), 32'h5A);
        $display("seq reset_mid_data -> stores=%0d wdata=%02h", n_store - b_store, wdata);

        check("exclusive_pulses", 32'(excl_viol), 32'd0);
        check("no_store_when_full", 32'(full_viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
